// File: rtl/fetch_pkg.sv
// Shared widths, reset PC and decode opcode constants for the fetch/decode front end.
package fetch_pkg;
  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 8;
  localparam int ENTRY_W = INSTR_W + ADDR_W;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 8'h00;

  // Opcode lives in instr[15:12]; decode matches against these.
  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_LOAD = 4'h8,
    OP_STOR = 4'h9,
    OP_BEQ  = 4'hC,
    OP_JMP  = 4'hE,
    OP_NOP  = 4'hF
  } opcode_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pcplus1;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: power-of-two FIFO with flush; head is read from registered storage only.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 24
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  // When empty, show the slot just behind rd_ptr so the last delivered entry holds.
  assign dout = empty ? mem[rd_ptr - PTR_W'(1)] : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= rd_ptr;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns fetch_pc, drives the combinational imem, and feeds IF/ID via a prefetch FIFO.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int                DEPTH    = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pcplus1
);
  // Handshake: a transfer to IF/ID happens exactly on cycles with out_valid && out_ready;
  // out_valid never depends on out_ready, and a redirect in the same cycle voids the pop.

  logic [ADDR_W-1:0]          fetch_pc;
  logic [$clog2(DEPTH+1)-1:0] fifo_count;
  logic                       fifo_empty;
  logic                       fifo_full;
  logic                       pop;
  logic                       push;
  fetch_entry_t               push_entry;
  fetch_entry_t               head_entry;

  assign imem_addr = fetch_pc;
  assign pop       = !fifo_empty && out_ready;
  assign push      = !redirect_valid && (!fifo_full || pop);

  assign push_entry.instr   = imem_instr;
  assign push_entry.pcplus1 = fetch_pc + 8'd1;

  assign out_valid   = (fifo_count != '0);
  assign out_instr   = head_entry.instr;
  assign out_pcplus1 = head_entry.pcplus1;

  always_ff @(posedge clk) begin
    if (!reset)              fetch_pc <= RESET_PC;
    else if (redirect_valid) fetch_pc <= redirect_pc;
    else if (push)           fetch_pc <= fetch_pc + 8'd1;
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head_entry),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// Directed + random bench for fetch_stage with imem[a] = 16'h1000 + a and an expected-instruction queue.
module tb_fetch_stage;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  imem_addr;
  logic [15:0] imem_instr;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [7:0]  out_pcplus1;

  logic [15:0] exp_q[$];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  assign imem_instr = 16'h1000 + {8'h00, imem_addr};

  fetch_stage #(.RESET_PC(8'h00), .DEPTH(DEPTH)) u_dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pcplus1    (out_pcplus1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled at the negedge; a pop is scored before the edge that performs it.
  task automatic tick();
    logic [15:0] e;
    logic [7:0]  epc;
    if (reset && !redirect_valid && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", {16'h0, out_instr}, 32'hFFFF_FFFF);
      end else begin
        e   = exp_q.pop_front();
        epc = e[7:0] + 8'd1;
        chk("pop_instr", {16'h0, out_instr}, {16'h0, e});
        chk("pop_pcplus1", {24'h0, out_pcplus1}, {24'h0, epc});
      end
    end
    chk("count_le_depth", {31'h0, (u_dut.u_fifo.count <= DEPTH)}, 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic push_seq(input logic [7:0] start, input int n);
    logic [7:0] a;
    a = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(16'h1000 + {8'h00, a});
      a = a + 8'd1;
    end
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    redirect_valid = 1'b0;
    tick();
    exp_q.delete();
    chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_out_instr", {16'h0, out_instr}, 32'h0);
    chk("rst_out_pcplus1", {24'h0, out_pcplus1}, 32'h0);
    chk("rst_fetch_pc", {24'h0, imem_addr}, 32'h0);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 8'h00;
    out_ready = 1'b1;
    @(negedge clk);

    // Streaming from reset with a always-ready consumer.
    reset_pulse();
    push_seq(8'h00, 8);
    tick();
    chk("first_valid", {31'h0, out_valid}, 32'd1);
    drain(20);

    // Back-pressure fills the buffer and stalls fetch_pc.
    out_ready = 1'b0;
    reset_pulse();
    push_seq(8'h00, 5);
    for (int i = 0; i < 6; i++) tick();
    chk("fill_fetch_pc", {24'h0, imem_addr}, DEPTH);
    chk("fill_head", {16'h0, out_instr}, 32'h1000);
    chk("fill_valid", {31'h0, out_valid}, 32'd1);
    chk("fill_count", {30'h0, u_dut.u_fifo.count}, DEPTH);
    out_ready = 1'b1;
    drain(20);

    // Redirect while full and consumer ready.
    redirect_valid = 1'b1;
    redirect_pc = 8'h40;
    tick();
    exp_q.delete();
    redirect_valid = 1'b0;
    chk("redir_bubble", {31'h0, out_valid}, 32'd0);
    chk("redir_fetch_pc", {24'h0, imem_addr}, 32'h40);
    push_seq(8'h40, 3);
    tick();
    chk("redir_head", {16'h0, out_instr}, 32'h1040);
    chk("redir_pcplus1", {24'h0, out_pcplus1}, 32'h41);
    drain(20);

    // Back-to-back redirects; last wins, then the address wraps.
    redirect_valid = 1'b1;
    redirect_pc = 8'h80;
    tick();
    redirect_pc = 8'hFE;
    tick();
    exp_q.delete();
    redirect_valid = 1'b0;
    chk("b2b_fetch_pc", {24'h0, imem_addr}, 32'hFE);
    chk("b2b_bubble", {31'h0, out_valid}, 32'd0);
    push_seq(8'hFE, 4);
    drain(20);

    // Reset mid-stream with two entries buffered and a redirect pending.
    out_ready = 1'b0;
    tick();
    tick();
    chk("pre_rst_count", {30'h0, u_dut.u_fifo.count}, 32'd2);
    reset = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 8'h55;
    out_ready = 1'b1;
    tick();
    exp_q.delete();
    chk("mid_rst_valid", {31'h0, out_valid}, 32'd0);
    chk("mid_rst_instr", {16'h0, out_instr}, 32'h0);
    chk("mid_rst_pcplus1", {24'h0, out_pcplus1}, 32'h0);
    chk("mid_rst_fetch_pc", {24'h0, imem_addr}, 32'h0);
    reset = 1'b1;
    redirect_valid = 1'b0;
    push_seq(8'h00, 4);
    tick();
    chk("restart_valid", {31'h0, out_valid}, 32'd1);
    drain(20);

    // Random back-pressure: consumed stream must stay strictly sequential.
    reset_pulse();
    push_seq(8'h00, 1100);
    for (int i = 0; i < 1000; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
